// File: rtl/seq_telemetry_uart_if.sv
// Bundles the send request, the nine decomposer results and the UART/status outputs.
// The master side drives the request and results; the slave side is the framer.
interface seq_telemetry_uart_if #(
  parameter int M = 14
);
  logic          send;
  logic [M-1:0]  Vzero_amp;
  logic [15:0]   Vzero_freq;
  logic [15:0]   Vzero_phase;
  logic [M-1:0]  Vpos_amp;
  logic [15:0]   Vpos_freq;
  logic [15:0]   Vpos_phase;
  logic [M-1:0]  Vneg_amp;
  logic [15:0]   Vneg_freq;
  logic [15:0]   Vneg_phase;
  logic          uart_tx;
  logic          busy;
  logic          frame_done;
  logic [7:0]    drop_cnt;

  modport master (
    output send,
    output Vzero_amp, Vzero_freq, Vzero_phase,
    output Vpos_amp, Vpos_freq, Vpos_phase,
    output Vneg_amp, Vneg_freq, Vneg_phase,
    input  uart_tx, busy, frame_done, drop_cnt
  );

  modport slave (
    input  send,
    input  Vzero_amp, Vzero_freq, Vzero_phase,
    input  Vpos_amp, Vpos_freq, Vpos_phase,
    input  Vneg_amp, Vneg_freq, Vneg_phase,
    output uart_tx, busy, frame_done, drop_cnt
  );
endinterface

// File: rtl/seq_telemetry_uart.sv
// Snapshots the nine sequence results on send and shifts them out as a 21-byte 8N1 frame.
// Latency: start bit driven on the edge that samples send; no backpressure, sends while busy are dropped and counted.
module seq_telemetry_uart #(
  parameter int M      = 14,
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic                  clk_100m,
  input  logic                  rst,
  seq_telemetry_uart_if.slave   bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [4:0]      byte_idx;
  logic [7:0]      sh;
  logic [159:0]    frame_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      drop_q;

  logic [143:0]    payload;
  logic [7:0]      chk_sum;
  logic [159:0]    frame_next;
  logic            bit_end;

  assign payload = {16'(bus.Vzero_amp),  16'(bus.Vpos_amp),  16'(bus.Vneg_amp),
                    bus.Vzero_freq,      bus.Vpos_freq,      bus.Vneg_freq,
                    bus.Vzero_phase,     bus.Vpos_phase,     bus.Vneg_phase};

  // Checksum is computed from the live inputs so it is captured together with the snapshot.
  always_comb begin
    chk_sum = 8'h00;
    for (int i = 0; i < 18; i++) begin
      chk_sum = chk_sum + payload[8*i +: 8];
    end
  end

  // Bytes 1..20 of the frame; byte 0 (0xA5) is loaded straight into the shifter.
  assign frame_next = {8'h5A, payload, chk_sum};
  assign bit_end    = (cnt == LAST);

  always_ff @(posedge clk_100m or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      sh       <= '0;
      frame_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      done_q <= 1'b0;

      if (bus.send && state != IDLE && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end

      if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          if (bus.send) begin
            state    <= START;
            sh       <= 8'hA5;
            frame_q  <= frame_next;
            cnt      <= '0;
            byte_idx <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx_q    <= sh[0];
            sh      <= {1'b0, sh[7:1]};
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= sh[0];
              sh      <= {1'b0, sh[7:1]};
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (byte_idx == 5'd20) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              // Next byte's start bit follows the stop bit with no gap.
              state    <= START;
              byte_idx <= byte_idx + 5'd1;
              sh       <= frame_q[159:152];
              frame_q  <= {frame_q[151:0], 8'h00};
              tx_q     <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.uart_tx    = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_seq_telemetry_uart.sv
// Scoreboard bench: expected frame bytes are queued at send time and popped by a UART decoder.
module tb_seq_telemetry_uart;
  localparam int M = 14;

  logic clk_100m = 1'b0;
  logic rst      = 1'b0;
  always #5 clk_100m = ~clk_100m;

  seq_telemetry_uart_if #(.M(M)) u_if ();

  seq_telemetry_uart #(.M(M), .CLK_HZ(1000000), .BAUD(100000)) dut (
    .clk_100m (clk_100m),
    .rst      (rst),
    .bus      (u_if)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  logic [M-1:0] za, pa, na;
  logic [15:0]  zf, pf, nf, zp, pp, np;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic apply_inputs();
    u_if.Vzero_amp = za;  u_if.Vpos_amp = pa;  u_if.Vneg_amp = na;
    u_if.Vzero_freq = zf; u_if.Vpos_freq = pf; u_if.Vneg_freq = nf;
    u_if.Vzero_phase = zp; u_if.Vpos_phase = pp; u_if.Vneg_phase = np;
  endtask

  task automatic rand_inputs();
    za = M'($urandom); pa = M'($urandom); na = M'($urandom);
    zf = 16'($urandom); pf = 16'($urandom); nf = 16'($urandom);
    zp = 16'($urandom); pp = 16'($urandom); np = 16'($urandom);
  endtask

  // Reference framing: header, nine MSB-first fields, sum of the payload bytes.
  task automatic push_exp();
    logic [15:0] f [9];
    logic [7:0]  sum;
    f[0] = {{(16-M){1'b0}}, za}; f[1] = {{(16-M){1'b0}}, pa}; f[2] = {{(16-M){1'b0}}, na};
    f[3] = zf; f[4] = pf; f[5] = nf; f[6] = zp; f[7] = pp; f[8] = np;
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(f[i][15:8]);
      exp_q.push_back(f[i][7:0]);
      sum = sum + f[i][15:8] + f[i][7:0];
    end
    exp_q.push_back(sum);
  endtask

  task automatic pulse_send();
    @(negedge clk_100m);
    u_if.send = 1'b1;
    @(negedge clk_100m);
    u_if.send = 1'b0;
  endtask

  // Decodes one frame with fixed 10-cycle bit slots, sampling mid-bit; returns at the frame_done cycle.
  task automatic capture(output int waited);
    logic [7:0] d;
    logic [7:0] e;
    logic       stop_bit;
    waited = 0;
    do begin
      @(negedge clk_100m);
      waited++;
    end while (u_if.uart_tx !== 1'b0 && waited < 60);
    if (u_if.uart_tx !== 1'b0) begin
      chk("start_timeout", 32'd1, 32'd0);
      return;
    end
    for (int b = 0; b < 21; b++) begin
      repeat (4) @(negedge clk_100m);
      chk("start_bit", {31'd0, u_if.uart_tx}, 32'd0);
      for (int k = 0; k < 8; k++) begin
        repeat (10) @(negedge clk_100m);
        d[k] = u_if.uart_tx;
      end
      repeat (10) @(negedge clk_100m);
      stop_bit = u_if.uart_tx;
      if (exp_q.size() == 0) begin
        chk("q_underflow", 32'd1, 32'd0);
        e = 8'h00;
      end else begin
        e = exp_q.pop_front();
      end
      chk($sformatf("byte%0d", b), {24'd0, d}, {24'd0, e});
      chk("stop_bit", {31'd0, stop_bit}, 32'd1);
      repeat (5) @(negedge clk_100m);
      if (b < 20) @(negedge clk_100m);
    end
    chk("busy_before_end", {31'd0, u_if.busy}, 32'd1);
    chk("done_early", {31'd0, u_if.frame_done}, 32'd0);
    @(negedge clk_100m);
    chk("frame_done_2100", {31'd0, u_if.frame_done}, 32'd1);
    chk("busy_end", {31'd0, u_if.busy}, 32'd0);
    chk("tx_idle_end", {31'd0, u_if.uart_tx}, 32'd1);
  endtask

  initial begin
    int w;
    int viol;
    u_if.send = 1'b0;
    za = '0; pa = '0; na = '0; zf = '0; pf = '0; nf = '0; zp = '0; pp = '0; np = '0;
    apply_inputs();

    repeat (3) @(negedge clk_100m);
    chk("rst_tx", {31'd0, u_if.uart_tx}, 32'd1);
    chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("rst_done", {31'd0, u_if.frame_done}, 32'd0);
    chk("rst_drop", {24'd0, u_if.drop_cnt}, 32'd0);
    rst = 1'b1;

    viol = 0;
    repeat (50) begin
      @(negedge clk_100m);
      if (u_if.uart_tx !== 1'b1 || u_if.busy !== 1'b0 || u_if.drop_cnt !== 8'd0) viol++;
    end
    chk("idle_50", viol, 0);

    // Single non-zero positive amplitude.
    pa = 14'h1234;
    apply_inputs();
    push_exp();
    fork
      capture(w);
      pulse_send();
    join
    chk("drop_a", {24'd0, u_if.drop_cnt}, 32'd0);

    // Full-scale values, then a send in the frame_done cycle.
    za = 14'h3FFF; pa = 14'h3FFF; na = 14'h3FFF;
    zf = 16'hFFFF; pf = 16'hFFFF; nf = 16'hFFFF;
    zp = 16'h8000; pp = 16'h8000; np = 16'h8000;
    apply_inputs();
    push_exp();
    fork
      capture(w);
      pulse_send();
    join
    u_if.send = 1'b1;
    push_exp();
    fork
      capture(w);
      begin
        @(negedge clk_100m);
        u_if.send = 1'b0;
      end
    join
    chk("b2b_gap", w, 1);
    chk("drop_b2b", {24'd0, u_if.drop_cnt}, 32'd0);

    // Drops and input changes while a frame is in flight.
    rand_inputs();
    apply_inputs();
    push_exp();
    fork
      capture(w);
      begin
        pulse_send();
        repeat (300) @(negedge clk_100m);
        repeat (3) begin
          u_if.send = 1'b1;
          @(negedge clk_100m);
          u_if.send = 1'b0;
          repeat (50) @(negedge clk_100m);
        end
        rand_inputs();
        apply_inputs();
      end
    join
    chk("drop_3", {24'd0, u_if.drop_cnt}, 32'd3);

    // Reset asserted during byte 7 bit 3.
    rand_inputs();
    apply_inputs();
    pulse_send();
    repeat (744) @(negedge clk_100m);
    chk("busy_midframe", {31'd0, u_if.busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_tx", {31'd0, u_if.uart_tx}, 32'd1);
    chk("abort_busy", {31'd0, u_if.busy}, 32'd0);
    chk("abort_drop", {24'd0, u_if.drop_cnt}, 32'd0);
    repeat (3) @(negedge clk_100m);
    rst = 1'b1;
    chk("q_empty_abort", exp_q.size(), 0);

    rand_inputs();
    apply_inputs();
    push_exp();
    fork
      capture(w);
      pulse_send();
    join
    chk("drop_after_rst", {24'd0, u_if.drop_cnt}, 32'd0);

    // Send held high: saturating drops, one frame per idle entry.
    rand_inputs();
    apply_inputs();
    push_exp();
    u_if.send = 1'b1;
    capture(w);
    chk("drop_sat", {24'd0, u_if.drop_cnt}, 32'd255);
    push_exp();
    fork
      capture(w);
      begin
        @(negedge clk_100m);
        u_if.send = 1'b0;
      end
    join
    chk("held_gap", w, 1);
    chk("drop_sat_hold", {24'd0, u_if.drop_cnt}, 32'd255);
    chk("q_empty_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
